cutie_tcdm_axi_lite_bridge: RTL and testbench
=============================================

// Module: cutie_tcdm_axi_lite_bridge
// PURPOSE
// - TCDM responder: accepts TCDM requests from a CUTIE-side TCDM initiator and replays each one as a single AXI-lite manager transaction.
// - Returns read data and completion to the initiator over the TCDM response.
// - Sits between CUTIE TCDM ports and the SoC AXI-lite interconnect.
// - One outstanding transaction; strictly in order.
// PARAMETERS
// - AxProt       3'b000  value driven on aw.prot and ar.prot
// - ErrCntWidth  16      width of err_cnt_o; used only with CUTIE_TCDM_BRIDGE_ERR_EN
// PORTS
// - clk_i       in   1    clock
// - rst_ni      in   1    asynchronous active-low reset
// - tcdm_req_i  in   70   cutie_pkg::tcdm_req_t {req, add[31:0], wen, wdata[31:0], be[3:0]}
// - tcdm_rsp_o  out  35   cutie_pkg::tcdm_rsp_t {gnt, r_opc, r_rdata[31:0], r_valid}
// - axi_req_o   out  111  cutie_pkg::axi_lite_req_t
// - axi_rsp_i   in   41   cutie_pkg::axi_lite_resp_t
// - err_cnt_o   out  ErrCntWidth  saturating AXI error count; present only with CUTIE_TCDM_BRIDGE_ERR_EN
// BEHAVIOUR
// - Clocking/reset: one clock (clk_i); reset is asynchronous, active-low (rst_ni).
// - Reset values:
//   - FSM = IDLE; all axi_req_o valids and readies = 0.
//   - tcdm_rsp_o = '0; captured address/data/be/wen = 0; err_cnt_o = 0.
// - TCDM encoding: wen=1 is a read, wen=0 is a write.
// - Grant:
//   - gnt = req & (state==IDLE); combinational, same cycle as req.
//   - req/add/wen/wdata/be are captured into registers on req&gnt.
//   - req while not IDLE is held off with gnt=0; initiator keeps req high.
// - States:
//   - IDLE: on req&gnt go to WR if wen=0, else RD.
//   - WR:
//     - aw_valid=1 with aw.addr=add; w_valid=1 with w.data=wdata, w.strb=be.
//     - AW and W complete independently; per-channel sent flags are set on their own ready; a channel's valid drops once its flag is set.
//     - Go to WB when both flags are set (same cycle allowed).
//   - WB: b_ready=1; on b_valid capture b.resp and go to RSP.
//   - RD: ar_valid=1, ar.addr=add; on ar_ready go to RB.
//   - RB: r_ready=1; on r_valid capture r.data and r.resp and go to RSP.
//   - RSP:
//     - r_valid=1 for exactly one cycle; r_rdata = read data (0 for writes); r_opc per ERR_EN rule.
//     - Returns to IDLE; gnt may assert in this RSP cycle's successor at the earliest.
// - Handshake rules:
//   - Valids, once raised, stay high with stable payload until ready.
//   - Payload is driven from registers only, never from tcdm_req_i.
//   - aw.addr/ar.addr are add unchanged; no alignment or masking applied.
// - Latency, zero-wait AXI:
//   - read: gnt cycle 0, ar cycle 1, r cycle 2, r_valid cycle 3.
//   - write: gnt 0, aw+w 1, b 2, r_valid 3.
// - Writes produce a r_valid completion; the initiator must not assume posted writes.
// - be=0 write is forwarded unchanged (strb=0).
// - rst_ni asserted mid-transaction:
//   - FSM returns to IDLE immediately, all valids drop, no r_valid is issued.
//   - The AXI side must be reset together.
// - r_valid/b_valid arriving outside RB/WB are never accepted (ready=0).
// CONFIGURATION
// - Macro CUTIE_TCDM_BRIDGE_ERR_EN defined:
//   - r_opc = 1 when captured resp != OKAY (SLVERR or DECERR).
//   - err_cnt_o increments by 1 on each such RSP and saturates at all-ones.
// - Macro undefined:
//   - r_opc tied 0; resp ignored.
//   - err_cnt_o port and counter absent.
// TESTING
// - Read: req=1, wen=1, add=0x1000_0040; slave returns 0xDEAD_BEEF OKAY with zero wait.
//   - Expect gnt in cycle 0, ar.addr=0x1000_0040 in cycle 1.
//   - Expect r_valid=1, r_rdata=0xDEAD_BEEF, r_opc=0 in cycle 3.
// - Write: wen=0, add=0x20, wdata=0x1234_5678, be=4'b0011.
//   - aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle; aw_valid held until ready.
//   - Exactly one r_valid after b.
// - Back-to-back: req held high for two requests; second gnt only after first r_valid.
//   - Expect no overlapping AXI valids.
// - Error (ERR_EN): read gets r.resp=SLVERR -> r_opc=1, err_cnt_o 0->1.
//   - 2^ErrCntWidth+3 errors -> err_cnt_o stays all-ones.
//   - Without ERR_EN -> r_opc=0.
// - Reset mid-op: rst_ni low while in RB.
//   - Expect all outputs 0 asynchronously, no r_valid after release, next request served normally.
// - Backpressure: b_valid stalled 10 cycles -> gnt=0 for all new requests meanwhile; tcdm r_valid only after b.

Source files
------------

// File: rtl/cutie_tcdm_axi_lite_bridge.sv
// CUTIE TCDM responder that replays each TCDM request as one AXI-lite manager transaction.
// Optional macro CUTIE_TCDM_BRIDGE_ERR_EN: AXI error reporting on r_opc plus saturating err_cnt_o.
package cutie_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } tcdm_req_t;

  typedef struct packed {
    logic        gnt;
    logic        r_opc;
    logic [31:0] r_rdata;
    logic        r_valid;
  } tcdm_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;
endpackage

// state | meaning
// IDLE  | waiting for a TCDM request, gnt follows req
// WR    | AW and W offered independently until both accepted
// WB    | waiting for the write response
// RD    | AR offered
// RB    | waiting for the read data
// RSP   | one-cycle TCDM completion
module cutie_tcdm_axi_lite_bridge #(
  parameter logic [2:0]  AxProt      = 3'b000,
  parameter int unsigned ErrCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  cutie_pkg::tcdm_req_t     tcdm_req_i,
  output cutie_pkg::tcdm_rsp_t     tcdm_rsp_o,
  output cutie_pkg::axi_lite_req_t axi_req_o,
  input  cutie_pkg::axi_lite_resp_t axi_rsp_i
`ifdef CUTIE_TCDM_BRIDGE_ERR_EN
  ,
  output logic [ErrCntWidth-1:0]   err_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, WR, WB, RD, RB, RSP} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_add, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic [1:0]  r_resp;
  logic        r_aw_sent, r_w_sent;
  logic        w_gnt, w_aw_done, w_w_done;

  // Gating with rst_ni keeps every output low while reset is held.
  assign w_gnt     = tcdm_req_i.req & (r_state == IDLE) & rst_ni;
  assign w_aw_done = r_aw_sent | axi_rsp_i.aw_ready;
  assign w_w_done  = r_w_sent  | axi_rsp_i.w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    axi_req_o        = '0;
    axi_req_o.aw.addr = r_add;
    axi_req_o.aw.prot = AxProt;
    axi_req_o.w.data  = r_wdata;
    axi_req_o.w.strb  = r_be;
    axi_req_o.ar.addr = r_add;
    axi_req_o.ar.prot = AxProt;
    case (r_state)
      IDLE: if (w_gnt) w_state_nxt = tcdm_req_i.wen ? RD : WR;
      WR: begin
        axi_req_o.aw_valid = ~r_aw_sent;
        axi_req_o.w_valid  = ~r_w_sent;
        if (w_aw_done && w_w_done) w_state_nxt = WB;
      end
      WB: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_rsp_i.b_valid) w_state_nxt = RSP;
      end
      RD: begin
        axi_req_o.ar_valid = 1'b1;
        if (axi_rsp_i.ar_ready) w_state_nxt = RB;
      end
      RB: begin
        axi_req_o.r_ready = 1'b1;
        if (axi_rsp_i.r_valid) w_state_nxt = RSP;
      end
      RSP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_add     <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_aw_sent <= 1'b0;
      r_w_sent  <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_add     <= tcdm_req_i.add;
        r_wdata   <= tcdm_req_i.wdata;
        r_be      <= tcdm_req_i.be;
        r_rdata   <= '0;
        r_resp    <= '0;
        r_aw_sent <= 1'b0;
        r_w_sent  <= 1'b0;
      end
      if (r_state == WR) begin
        if (axi_rsp_i.aw_ready) r_aw_sent <= 1'b1;
        if (axi_rsp_i.w_ready)  r_w_sent  <= 1'b1;
      end
      if (r_state == WB && axi_rsp_i.b_valid) r_resp <= axi_rsp_i.b.resp;
      if (r_state == RB && axi_rsp_i.r_valid) begin
        r_rdata <= axi_rsp_i.r.data;
        r_resp  <= axi_rsp_i.r.resp;
      end
    end
  end

  assign tcdm_rsp_o.gnt     = w_gnt;
  assign tcdm_rsp_o.r_valid = (r_state == RSP);
  assign tcdm_rsp_o.r_rdata = (r_state == RSP) ? r_rdata : '0;

`ifdef CUTIE_TCDM_BRIDGE_ERR_EN
  logic [ErrCntWidth-1:0] r_err_cnt;

  assign tcdm_rsp_o.r_opc = (r_state == RSP) && (r_resp != 2'b00);
  assign err_cnt_o        = r_err_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (r_state == RSP && r_resp != 2'b00 && r_err_cnt != '1) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end
`else
  logic w_unused;

  // Response codes are only meaningful when error reporting is built in.
  assign tcdm_rsp_o.r_opc = 1'b0;
  assign w_unused         = ^{r_resp, ErrCntWidth[0]};
`endif

endmodule

// File: tb/tb_cutie_tcdm_axi_lite_bridge.sv
// Directed cycle-exact bench for cutie_tcdm_axi_lite_bridge; builds with or without CUTIE_TCDM_BRIDGE_ERR_EN.
module tb_cutie_tcdm_axi_lite_bridge;

`ifdef CUTIE_TCDM_BRIDGE_ERR_EN
  localparam int unsigned ECW = 3;
  localparam logic        ExpOpc = 1'b1;
`else
  localparam int unsigned ECW = 16;
  localparam logic        ExpOpc = 1'b0;
`endif

  logic                      clk_i;
  logic                      rst_ni;
  cutie_pkg::tcdm_req_t      tcdm_req;
  cutie_pkg::tcdm_rsp_t      tcdm_rsp;
  cutie_pkg::axi_lite_req_t  axi_req;
  cutie_pkg::axi_lite_resp_t axi_rsp;
`ifdef CUTIE_TCDM_BRIDGE_ERR_EN
  logic [ECW-1:0]            err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cutie_tcdm_axi_lite_bridge #(.AxProt(3'b000), .ErrCntWidth(ECW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tcdm_req_i (tcdm_req),
    .tcdm_rsp_o (tcdm_rsp),
    .axi_req_o  (axi_req),
    .axi_rsp_i  (axi_rsp)
`ifdef CUTIE_TCDM_BRIDGE_ERR_EN
    ,
    .err_cnt_o  (err_cnt)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // {aw_valid, w_valid, b_ready, ar_valid, r_ready}
  function automatic logic [4:0] ctl();
    return {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready};
  endfunction

  // Zero-wait read, entered and left at 1 time unit after a rising edge in IDLE.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs,
                         output logic [31:0] rd, output logic opc, output logic vld);
    tcdm_req     = '0;
    tcdm_req.req = 1'b1;
    tcdm_req.wen = 1'b1;
    tcdm_req.add = a;
    cyc();
    tcdm_req.req     = 1'b0;
    axi_rsp.ar_ready = 1'b1;
    cyc();
    axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid  = 1'b1;
    axi_rsp.r.data   = d;
    axi_rsp.r.resp   = rs;
    cyc();
    axi_rsp.r_valid = 1'b0;
    rd  = tcdm_rsp.r_rdata;
    opc = tcdm_rsp.r_opc;
    vld = tcdm_rsp.r_valid;
    cyc();
  endtask

  logic [31:0] rd;
  logic        opc, vld;

  initial begin
    rst_ni   = 1'b0;
    tcdm_req = '0;
    axi_rsp  = '0;
    #3;
    chk("rst_tcdm_rsp", 64'(tcdm_rsp), 64'(0));
    chk("rst_axi_req", 64'(axi_req), 64'(0));
    tcdm_req.req = 1'b1;
    #1;
    chk("rst_gnt", 64'(tcdm_rsp.gnt), 64'(0));
    tcdm_req = '0;
    #10;
    rst_ni = 1'b1;
    cyc();

    // read, zero-wait slave
    tcdm_req = '{req: 1'b1, add: 32'h1000_0040, wen: 1'b1, wdata: 32'hA5A5_A5A5, be: 4'hF};
    #1;
    chk("rd_gnt_c0", 64'(tcdm_rsp.gnt), 64'(1));
    chk("rd_ctl_c0", 64'(ctl()), 64'(5'b00000));
    cyc();
    tcdm_req     = '0;
    tcdm_req.add = 32'hFFFF_FFFF;
    axi_rsp.ar_ready = 1'b1;
    #1;
    chk("rd_ctl_c1", 64'(ctl()), 64'(5'b00010));
    chk("rd_ar_addr", 64'(axi_req.ar.addr), 64'(32'h1000_0040));
    chk("rd_ar_prot", 64'(axi_req.ar.prot), 64'(0));
    cyc();
    axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid  = 1'b1;
    axi_rsp.r.data   = 32'hDEAD_BEEF;
    axi_rsp.r.resp   = 2'b00;
    #1;
    chk("rd_ctl_c2", 64'(ctl()), 64'(5'b00001));
    chk("rd_rvalid_c2", 64'(tcdm_rsp.r_valid), 64'(0));
    cyc();
    axi_rsp.r_valid = 1'b0;
    chk("rd_rvalid_c3", 64'(tcdm_rsp.r_valid), 64'(1));
    chk("rd_rdata", 64'(tcdm_rsp.r_rdata), 64'(32'hDEAD_BEEF));
    chk("rd_opc", 64'(tcdm_rsp.r_opc), 64'(0));
    chk("rd_ctl_c3", 64'(ctl()), 64'(5'b00000));
    cyc();
    chk("rd_rvalid_c4", 64'(tcdm_rsp.r_valid), 64'(0));

    // write, AW accepted late, W immediately
    tcdm_req = '{req: 1'b1, add: 32'h0000_0020, wen: 1'b0, wdata: 32'h1234_5678, be: 4'b0011};
    #1;
    chk("wr_gnt", 64'(tcdm_rsp.gnt), 64'(1));
    cyc();
    tcdm_req = '0;
    axi_rsp.w_ready = 1'b1;
    chk("wr_ctl_c1", 64'(ctl()), 64'(5'b11000));
    chk("wr_aw_addr", 64'(axi_req.aw.addr), 64'(32'h20));
    chk("wr_w_data", 64'(axi_req.w.data), 64'(32'h1234_5678));
    chk("wr_w_strb", 64'(axi_req.w.strb), 64'(4'b0011));
    cyc();
    axi_rsp.w_ready = 1'b0;
    axi_rsp.b_valid = 1'b1;
    chk("wr_ctl_c2", 64'(ctl()), 64'(5'b10000));
    cyc();
    axi_rsp.b_valid = 1'b0;
    chk("wr_ctl_c3", 64'(ctl()), 64'(5'b10000));
    chk("wr_aw_hold", 64'(axi_req.aw.addr), 64'(32'h20));
    cyc();
    axi_rsp.aw_ready = 1'b1;
    chk("wr_ctl_c4", 64'(ctl()), 64'(5'b10000));
    cyc();
    axi_rsp.aw_ready = 1'b0;
    chk("wr_ctl_c5", 64'(ctl()), 64'(5'b00100));
    axi_rsp.b_valid = 1'b1;
    axi_rsp.b.resp  = 2'b00;
    cyc();
    axi_rsp.b_valid = 1'b0;
    chk("wr_rvalid", 64'(tcdm_rsp.r_valid), 64'(1));
    chk("wr_rdata", 64'(tcdm_rsp.r_rdata), 64'(0));
    cyc();
    chk("wr_rvalid_once", 64'(tcdm_rsp.r_valid), 64'(0));

    // back-to-back: be=0 write with stalled B, then an error read waiting on req
    tcdm_req = '{req: 1'b1, add: 32'h0000_0044, wen: 1'b0, wdata: 32'hCAFE_F00D, be: 4'b0000};
    #1;
    chk("b2b_gnt1", 64'(tcdm_rsp.gnt), 64'(1));
    cyc();
    tcdm_req = '{req: 1'b1, add: 32'h1000_0080, wen: 1'b1, wdata: 32'h0, be: 4'hF};
    axi_rsp.aw_ready = 1'b1;
    axi_rsp.w_ready  = 1'b1;
    chk("b2b_ctl_wr", 64'(ctl()), 64'(5'b11000));
    chk("b2b_strb0", 64'(axi_req.w.strb), 64'(0));
    chk("b2b_wdata", 64'(axi_req.w.data), 64'(32'hCAFE_F00D));
    chk("b2b_gnt_busy", 64'(tcdm_rsp.gnt), 64'(0));
    cyc();
    axi_rsp.aw_ready = 1'b0;
    axi_rsp.w_ready  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bstall_%0d", i), 64'({tcdm_rsp.gnt, tcdm_rsp.r_valid, ctl()}), 64'(7'b0000100));
      cyc();
    end
    axi_rsp.b_valid = 1'b1;
    chk("bstall_end", 64'({tcdm_rsp.gnt, ctl()}), 64'(6'b000100));
    cyc();
    axi_rsp.b_valid = 1'b0;
    chk("b2b_rsp", 64'({tcdm_rsp.gnt, tcdm_rsp.r_valid, ctl()}), 64'(7'b0100000));
    cyc();
    chk("b2b_gnt2", 64'({tcdm_rsp.gnt, tcdm_rsp.r_valid}), 64'(2'b10));
    cyc();
    tcdm_req = '0;
    axi_rsp.ar_ready = 1'b1;
    chk("b2b_ctl_rd", 64'(ctl()), 64'(5'b00010));
    chk("b2b_ar_addr", 64'(axi_req.ar.addr), 64'(32'h1000_0080));
    cyc();
    axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid  = 1'b1;
    axi_rsp.r.data   = 32'h0BAD_F00D;
    axi_rsp.r.resp   = 2'b10;
    cyc();
    axi_rsp.r_valid = 1'b0;
    chk("err_rvalid", 64'(tcdm_rsp.r_valid), 64'(1));
    chk("err_rdata", 64'(tcdm_rsp.r_rdata), 64'(32'h0BAD_F00D));
    chk("err_opc", 64'(tcdm_rsp.r_opc), 64'(ExpOpc));
    cyc();
`ifdef CUTIE_TCDM_BRIDGE_ERR_EN
    chk("err_cnt_1", 64'(err_cnt), 64'(1));
    for (int i = 0; i < 10; i++) do_read(32'h100 + 32'(i), 32'h0, 2'b11, rd, opc, vld);
    chk("err_cnt_sat", 64'(err_cnt), 64'(3'b111));
    chk("err_sat_opc", 64'(opc), 64'(1));
`endif

    // reset while waiting in RB
    tcdm_req = '{req: 1'b1, add: 32'h0000_0300, wen: 1'b1, wdata: 32'h0, be: 4'hF};
    cyc();
    tcdm_req = '0;
    axi_rsp.ar_ready = 1'b1;
    cyc();
    axi_rsp.ar_ready = 1'b0;
    chk("rstmid_in_rb", 64'(ctl()), 64'(5'b00001));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstmid_axi_req", 64'(axi_req), 64'(0));
    chk("rstmid_tcdm_rsp", 64'(tcdm_rsp), 64'(0));
    axi_rsp.r_valid = 1'b1;
    axi_rsp.r.data  = 32'h7777_7777;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("rstmid_quiet_%0d", i), 64'({tcdm_rsp.r_valid, ctl()}), 64'(6'b000000));
    end
    axi_rsp.r_valid = 1'b0;
    do_read(32'h0000_0400, 32'h5555_AAAA, 2'b00, rd, opc, vld);
    chk("post_rst_vld", 64'(vld), 64'(1));
    chk("post_rst_rdata", 64'(rd), 64'(32'h5555_AAAA));
    chk("post_rst_opc", 64'(opc), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
